// File: rtl/io_bus_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ1,
    READ2,
    DONE
  } state_t;

  localparam int         NUM_MASTERS       = 2;
  localparam logic [7:0] IDLE_ADDR_DEFAULT = 8'hFF;
  localparam logic [7:0] LED_BASE          = 8'hC0;

  // One master's request fields, captured as a unit when it wins.
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
  } txn_t;

endpackage

// File: rtl/io_bus_arb_pick.sv
// Winner selection between the two masters.
// Define ROUND_ROBIN_EN to alternate on simultaneous requests; otherwise master 0 always wins.
module io_bus_arb_pick
  import io_bus_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] last_grant,
  output logic [NUM_MASTERS-1:0] grant
);

`ifndef ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = '0;
    if (req == 2'b11) begin
`ifdef ROUND_ROBIN_EN
      grant = (last_grant == 2'b01) ? 2'b10 : 2'b01;
`else
      grant = 2'b01;
`endif
    end else if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter driving a shared 8-bit IO bus (one-cycle write, two-cycle read).
// Arbitration policy is set by the ROUND_ROBIN_EN macro in io_bus_arb_pick.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter logic [7:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_0,
  input  logic       REQ_1,
  input  logic [7:0] ADDR_0,
  input  logic [7:0] ADDR_1,
  input  logic [7:0] WDATA_0,
  input  logic [7:0] WDATA_1,
  input  logic       WE_0,
  input  logic       WE_1,
  output logic       DONE_0,
  output logic       DONE_1,
  output logic [7:0] RDATA,
  output logic [1:0] GRANT,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA
);

  state_t     state;
  txn_t       txn;
  txn_t       cand;
  logic       drive;
  logic [1:0] req_vec;
  logic [1:0] pick;
  logic [1:0] last_grant;

  assign req_vec = {REQ_1, REQ_0};

  io_bus_arb_pick u_pick (
    .req       (req_vec),
    .last_grant(last_grant),
    .grant     (pick)
  );

  always_comb begin
    cand = '{addr: ADDR_0, wdata: WDATA_0, we: WE_0};
    if (pick[1]) cand = '{addr: ADDR_1, wdata: WDATA_1, we: WE_1};
  end

  // The arbiter owns the data lines only during WRITE.
  assign BUS_DATA = drive ? txn.wdata : 8'hzz;

  // NOTE: txn is deliberately left out of reset; it is always loaded before it is used.
  always_ff @(posedge CLK) begin
    if (state == IDLE && |req_vec) txn <= cand;
  end

  // NOTE: non-blocking assignments so every register here updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      GRANT      <= 2'b00;
      DONE_0     <= 1'b0;
      DONE_1     <= 1'b0;
      BUS_WE     <= 1'b0;
      BUS_ADDR   <= IDLE_ADDR;
      drive      <= 1'b0;
      RDATA      <= 8'h00;
      last_grant <= 2'b10;
    end else begin
      DONE_0 <= 1'b0;
      DONE_1 <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_vec) begin
            GRANT      <= pick;
            last_grant <= pick;
            BUS_ADDR   <= cand.addr;
            BUS_WE     <= cand.we;
            drive      <= cand.we;
            state      <= cand.we ? WRITE : READ1;
          end
        end
        WRITE: begin
          BUS_WE           <= 1'b0;
          drive            <= 1'b0;
          BUS_ADDR         <= IDLE_ADDR;
          {DONE_1, DONE_0} <= GRANT;
          state            <= DONE;
        end
        READ1: state <= READ2;
        READ2: begin
          RDATA            <= BUS_DATA;
          BUS_ADDR         <= IDLE_ADDR;
          {DONE_1, DONE_0} <= GRANT;
          state            <= DONE;
        end
        DONE: begin
          GRANT <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized self-checking bench for io_bus_arbiter against a transaction-level model.
module tb_io_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_0, REQ_1;
  logic [7:0] ADDR_0, ADDR_1, WDATA_0, WDATA_1;
  logic       WE_0, WE_1;
  wire        DONE_0, DONE_1;
  wire  [7:0] RDATA;
  wire  [1:0] GRANT;
  wire  [7:0] BUS_ADDR;
  wire        BUS_WE;
  wire  [7:0] BUS_DATA;

  always #5 CLK = ~CLK;

  io_bus_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_0(REQ_0), .REQ_1(REQ_1),
    .ADDR_0(ADDR_0), .ADDR_1(ADDR_1),
    .WDATA_0(WDATA_0), .WDATA_1(WDATA_1),
    .WE_0(WE_0), .WE_1(WE_1),
    .DONE_0(DONE_0), .DONE_1(DONE_1),
    .RDATA(RDATA), .GRANT(GRANT),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA(BUS_DATA)
  );

  // Peripheral space: every address except FF answers reads; C0 is the LED register.
  logic [7:0] periph_mem [256];
  assign BUS_DATA = (BUS_WE === 1'b0 && BUS_ADDR !== 8'hFF && !$isunknown(BUS_ADDR))
                    ? periph_mem[BUS_ADDR] : 8'hzz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one transaction record plus expected memory image.
  logic [7:0] mem_exp [256];
  bit         busy = 0;
  int         owner = 0;
  bit         m_wr = 0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;
  int         age = 0;
  int         last_owner = 1;
  logic [7:0] rdata_exp = 8'h00;
  bit         exp_done0, exp_done1;
  logic [1:0] prev_grant = 2'b00;
  int         dut_grants[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int txn_len(input bit wr);
    return wr ? 2 : 3;
  endfunction

  // Write: bus cycle, done cycle. Read: two bus cycles, done cycle. One idle cycle follows.
  task automatic model_edge();
    if (RESET) begin
      busy       = 0;
      rdata_exp  = 8'h00;
      last_owner = 1;
    end else if (busy) begin
      age++;
      if (!m_wr && age == 2) rdata_exp = mem_exp[m_addr];
      if (age == txn_len(m_wr)) busy = 0;
    end else if (REQ_0 || REQ_1) begin
      if (REQ_0 && REQ_1) begin
`ifdef ROUND_ROBIN_EN
        owner = 1 - last_owner;
`else
        owner = 0;
`endif
      end else begin
        owner = REQ_0 ? 0 : 1;
      end
      last_owner = owner;
      busy   = 1;
      age    = 0;
      m_wr   = (owner == 0) ? WE_0 : WE_1;
      m_addr = (owner == 0) ? ADDR_0 : ADDR_1;
      m_data = (owner == 0) ? WDATA_0 : WDATA_1;
      if (m_wr) mem_exp[m_addr] = m_data;
    end
  endtask

  task automatic step();
    bit bus_phase, done_phase;
    @(posedge CLK);
    #1;
    model_edge();
    bus_phase  = busy && (age < txn_len(m_wr) - 1);
    done_phase = busy && (age == txn_len(m_wr) - 1);
    exp_done0  = done_phase && owner == 0;
    exp_done1  = done_phase && owner == 1;
    check("grant",    GRANT,    busy ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00);
    check("done_0",   DONE_0,   exp_done0);
    check("done_1",   DONE_1,   exp_done1);
    check("bus_we",   BUS_WE,   bus_phase && m_wr);
    check("bus_addr", BUS_ADDR, bus_phase ? m_addr : 8'hFF);
    check("bus_data", BUS_DATA, !bus_phase ? 8'hzz : (m_wr ? m_data : mem_exp[m_addr]));
    check("rdata",    RDATA,    rdata_exp);
    if (BUS_WE === 1'b1 && !$isunknown(BUS_ADDR)) periph_mem[BUS_ADDR] = BUS_DATA;
    if (prev_grant == 2'b00 && GRANT == 2'b01) dut_grants.push_back(0);
    if (prev_grant == 2'b00 && GRANT == 2'b10) dut_grants.push_back(1);
    prev_grant = GRANT;
  endtask

  task automatic set_master(input int m, input bit r, input bit we,
                            input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin REQ_0 = r; WE_0 = we; ADDR_0 = a; WDATA_0 = d; end
    else        begin REQ_1 = r; WE_1 = we; ADDR_1 = a; WDATA_1 = d; end
  endtask

  // Issues one request, measures cycles to the DUT's DONE; optionally disturbs inputs mid-write.
  task automatic issue(input int m, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input bit disturb, output int lat);
    lat = -1;
    set_master(m, 1'b1, wr, a, d);
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      step();
      if (((m == 0) ? DONE_0 : DONE_1) === 1'b1) lat = i;
      else if (disturb && i == 1) set_master(m, 1'b0, ~wr, 8'h33, 8'hEE);
    end
    if (m == 0) REQ_0 = 1'b0; else REQ_1 = 1'b0;
    check($sformatf("latency_m%0d_%s", m, wr ? "wr" : "rd"), lat[15:0], wr ? 16'd2 : 16'd3);
  endtask

  initial begin
    int lat;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      periph_mem[i] = v;
      mem_exp[i]    = v;
    end
    RESET = 1'b1;
    set_master(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_master(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();

    // Reset during READ2 aborts the read without a DONE pulse.
    RESET = 1'b0;
    set_master(0, 1'b1, 1'b0, 8'h10, 8'h00);
    step();
    step();
    RESET = 1'b1;
    REQ_0 = 1'b0;
    step();
    check("rst_read2_grant", GRANT, 2'b00);
    check("rst_read2_addr", BUS_ADDR, 8'hFF);
    check("rst_read2_rdata", RDATA, 8'h00);
    RESET = 1'b0;
    step();

    // Master 0 writes 5A to the LED register; inputs disturbed while the write is on the bus.
    issue(0, 1'b1, 8'hC0, 8'h5A, 1'b1, lat);
    step();
    step();
    check("leds", periph_mem[8'hC0], 8'h5A);

    // Master 1 reads it back.
    issue(1, 1'b0, 8'hC0, 8'h00, 1'b0, lat);
    check("read_back", RDATA, 8'h5A);
    step();
    step();

    // Both masters request continuously.
    dut_grants.delete();
    set_master(0, 1'b1, 1'b1, 8'h20, 8'h11);
    set_master(1, 1'b1, 1'b1, 8'h21, 8'h22);
    for (int i = 0; i < 30; i++) step();
    REQ_0 = 1'b0;
    REQ_1 = 1'b0;
    ok = dut_grants.size() >= 4;
    check("both_count", ok, 1'b1);
    for (int k = 0; k < dut_grants.size() && k < 6; k++) begin
`ifdef ROUND_ROBIN_EN
      check($sformatf("both_grant_%0d", k), dut_grants[k][15:0], 16'(k % 2));
`else
      check($sformatf("both_grant_%0d", k), dut_grants[k][15:0], 16'd0);
`endif
    end
    step();
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      RESET = ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        bit r, done_m, inflight;
        r        = (m == 0) ? REQ_0 : REQ_1;
        done_m   = (m == 0) ? exp_done0 : exp_done1;
        inflight = busy && owner == m && !done_m;
        if (!r) begin
          if ($urandom_range(0, 2) == 0)
            set_master(m, 1'b1, 1'($urandom), 8'($urandom_range(0, 254)), 8'($urandom));
        end else if (done_m) begin
          set_master(m, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 254)), 8'($urandom));
        end else if (inflight) begin
          set_master(m, 1'b1, 1'($urandom), 8'($urandom_range(0, 254)), 8'($urandom));
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter IDLE_ADDR, default 8'hFF, SHALL be the address driven on BUS_ADDR when no transaction is in progress; no peripheral decodes it.
REQ-002 CLK  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-003 RESET  input  1  SHALL be the synchronous, active-high reset.
REQ-004 REQ_0, REQ_1  input  1 each  SHALL be the transaction requests from master 0 (CPU) and master 1 (auxiliary).
REQ-005 ADDR_0, ADDR_1  input  8 each  SHALL be the target bus addresses.
REQ-006 WDATA_0, WDATA_1  input  8 each  SHALL be the write data.
REQ-007 WE_0, WE_1  input  1 each  SHALL select write (1) or read (0).
REQ-008 DONE_0, DONE_1  output  1 each  SHALL be single-cycle completion pulses.
REQ-009 RDATA  output  8  SHALL hold read data, valid in the DONE cycle of a read.
REQ-010 GRANT  output  2  SHALL be one-hot owner of the current transaction, 2'b00 when idle.
REQ-011 BUS_ADDR  output  8, BUS_WE  output  1, BUS_DATA  inout  8  SHALL form the shared IO bus.

Function
REQ-012 The FSM SHALL have states IDLE, WRITE, READ1, READ2, DONE.
REQ-013 In IDLE with any REQ high, the block SHALL choose a winner, latch its ADDR/WDATA/WE, set GRANT, and enter WRITE (WE=1) or READ1 (WE=0).
REQ-014 WRITE SHALL drive BUS_ADDR=latched addr, BUS_DATA=latched data, BUS_WE=1 for exactly one cycle, then enter DONE.
REQ-015 READ1 and READ2 SHALL drive BUS_ADDR=latched addr with BUS_WE=0 and BUS_DATA released to 'Z'.
REQ-016 At the rising edge ending READ2, RDATA SHALL capture BUS_DATA, and the FSM SHALL enter DONE.
REQ-017 DONE SHALL pulse DONE_x of the granted master for one cycle, clear GRANT and BUS_WE, and return to IDLE.
REQ-018 Latency from request edge SHALL be: write DONE 2 cycles later, read DONE 3 cycles later; back-to-back issue is possible from the IDLE cycle after DONE.
REQ-019 BUS_DATA SHALL be driven only in WRITE; BUS_WE SHALL be 1 only in WRITE; BUS_ADDR SHALL be IDLE_ADDR in IDLE and DONE.
REQ-020 Fields SHALL be latched once; REQ or input changes after latching SHALL NOT affect the transaction in flight.
REQ-021 A master SHALL hold REQ until its DONE; a REQ still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-022 RDATA SHALL keep its last value until the next read capture.

Reset
REQ-023 On RESET, state SHALL be IDLE, GRANT=2'b00, DONE_0=DONE_1=0, BUS_WE=0, BUS_ADDR=IDLE_ADDR, BUS_DATA='Z', RDATA=8'h00, and the round-robin pointer SHALL favour master 0.
REQ-024 RESET mid-transaction SHALL abort it with no DONE pulse and release the bus in the next cycle.

Configuration
REQ-025 With ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the master not granted most recently.
REQ-026 Without ROUND_ROBIN_EN, master 0 SHALL always win simultaneous requests (fixed priority).

Structure
REQ-027 Package io_bus_pkg SHALL hold the state enum, IDLE_ADDR default, and peripheral base constants (LED base 8'hC0).
REQ-028 Winner selection SHALL be a sub-module io_bus_arb_pick (requests and last-grant in, one-hot grant out).

Verification
REQ-029 Master 0 writes 8'h5A to 8'hC0 -> BUS_WE high for one cycle with BUS_ADDR=C0 and BUS_DATA=5A; DONE_0 two cycles after the request edge; LEDs=5A later.
REQ-030 Master 1 reads 8'hC0 after the write -> DONE_1 three cycles after the request with RDATA=8'h5A; BUS_DATA is 'Z' from the arbiter throughout.
REQ-031 Both masters request continuously -> with ROUND_ROBIN_EN, grants alternate 0,1,0,1; without it, master 0 is granted every time.
REQ-032 RESET asserted in READ2 -> no DONE pulse, GRANT=00, BUS_ADDR=FF the next cycle, and RDATA unchanged from 00.
REQ-033 ADDR_0 changed and REQ_0 dropped during WRITE -> the bus still shows the originally latched address and data, and DONE_0 pulses.
